// File: rtl/reg_file_mp_sb.sv
// reg_file_mp_sb: parametrised multi-port register file with same-cycle
// write-to-read bypass and a per-register pending (busy) scoreboard.
// Register 0 is hardwired to zero and never reports busy.
module reg_file_mp_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int READ_PORT  = 4,
    parameter int WRITE_PORT = 2,
    parameter int BYPASS     = 1,
    parameter int RESET_NEED = 1,
    localparam int ADDR_W    = $clog2(REG_NUM)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [READ_PORT-1:0][ADDR_W-1:0]       r_addr_i,
    output logic [READ_PORT-1:0][DATA_WIDTH-1:0]   r_data_o,
    output logic [READ_PORT-1:0]                   r_busy_o,
    input  logic [WRITE_PORT-1:0][ADDR_W-1:0]      w_addr_i,
    input  logic [WRITE_PORT-1:0][DATA_WIDTH-1:0]  w_data_i,
    input  logic [WRITE_PORT-1:0]                  w_en_i,
    input  logic [WRITE_PORT-1:0][ADDR_W-1:0]      iss_addr_i,
    input  logic [WRITE_PORT-1:0]                  iss_en_i,
    output logic                                   conflict_o
);

    logic [REG_NUM-1:0][DATA_WIDTH-1:0] regs;
    logic [REG_NUM-1:0]                 busy;
    logic [REG_NUM-1:0]                 busy_nxt;

    // Data array: writeback ports applied in ascending order so the highest-index port wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (RESET_NEED != 0) begin
                regs <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < WRITE_PORT; p++) begin
                if (w_en_i[p] && (w_addr_i[p] != '0)) begin
                    regs[w_addr_i[p]] <= w_data_i[p];
                end
            end
        end
    end

    // Scoreboard next state: writeback clears first, then issue sets so issue wins.
    always_comb begin
        busy_nxt = busy;
        for (int unsigned p = 0; p < WRITE_PORT; p++) begin
            if (w_en_i[p]) begin
                busy_nxt[w_addr_i[p]] = 1'b0;
            end
        end
        for (int unsigned p = 0; p < WRITE_PORT; p++) begin
            if (iss_en_i[p]) begin
                busy_nxt[iss_addr_i[p]] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Read ports: stored value, overridden by the highest-index matching write when bypassing.
    always_comb begin
        r_data_o = '0;
        r_busy_o = '0;
        for (int unsigned k = 0; k < READ_PORT; k++) begin
            r_data_o[k] = regs[r_addr_i[k]];
            r_busy_o[k] = busy[r_addr_i[k]];
            if (BYPASS != 0) begin
                for (int unsigned p = 0; p < WRITE_PORT; p++) begin
                    if (w_en_i[p] && (w_addr_i[p] == r_addr_i[k])) begin
                        r_data_o[k] = w_data_i[p];
                        r_busy_o[k] = 1'b0;
                    end
                end
            end
            if (r_addr_i[k] == '0) begin
                r_data_o[k] = '0;
                r_busy_o[k] = 1'b0;
            end
            if (!rst_n) begin
                r_busy_o[k] = 1'b0;
                if (RESET_NEED != 0) begin
                    r_data_o[k] = '0;
                end
            end
        end
    end

    // Conflict detect: any pair of enabled write ports hitting the same nonzero register.
    always_comb begin
        conflict_o = 1'b0;
        for (int unsigned p = 0; p < WRITE_PORT; p++) begin
            for (int unsigned q = p + 1; q < WRITE_PORT; q++) begin
                if (w_en_i[p] && w_en_i[q] && (w_addr_i[p] != '0) &&
                    (w_addr_i[p] == w_addr_i[q])) begin
                    conflict_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Scoreboard bench for reg_file_mp_sb (default parameters): a driver applies
// directed and random cycles, predicts outputs from an array model and queues
// them; a monitor on the falling edge pops and compares.
module tb_reg_file_mp_sb;

    localparam int DW = 32;
    localparam int RN = 32;
    localparam int RP = 4;
    localparam int WP = 2;
    localparam int AW = 5;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [RP-1:0][AW-1:0]  r_addr;
    logic [RP-1:0][DW-1:0]  r_data;
    logic [RP-1:0]          r_busy;
    logic [WP-1:0][AW-1:0]  w_addr;
    logic [WP-1:0][DW-1:0]  w_data;
    logic [WP-1:0]          w_en;
    logic [WP-1:0][AW-1:0]  iss_addr;
    logic [WP-1:0]          iss_en;
    logic                   conflict;

    reg_file_mp_sb #(
        .DATA_WIDTH (DW),
        .REG_NUM    (RN),
        .READ_PORT  (RP),
        .WRITE_PORT (WP),
        .BYPASS     (1),
        .RESET_NEED (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .r_addr_i   (r_addr),
        .r_data_o   (r_data),
        .r_busy_o   (r_busy),
        .w_addr_i   (w_addr),
        .w_data_i   (w_data),
        .w_en_i     (w_en),
        .iss_addr_i (iss_addr),
        .iss_en_i   (iss_en),
        .conflict_o (conflict)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RP-1:0][DW-1:0] data;
        logic [RP-1:0]         busy;
        logic                  conf;
    } exp_t;

    exp_t        exp_q[$];
    logic [DW-1:0] mreg  [RN];
    bit            mbusy [RN];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          done     = 1'b0;

    // Architectural view of the current cycle: what a reader must observe.
    function automatic exp_t predict();
        exp_t e;
        int   hits;
        e = '0;
        for (int k = 0; k < RP; k++) begin
            int a = int'(r_addr[k]);
            if (rst_n && a != 0) begin
                int last = -1;
                for (int p = 0; p < WP; p++)
                    if (w_en[p] && int'(w_addr[p]) == a) last = p;
                if (last >= 0) begin
                    e.data[k] = w_data[last];
                    e.busy[k] = 1'b0;
                end else begin
                    e.data[k] = mreg[a];
                    e.busy[k] = mbusy[a];
                end
            end
        end
        for (int a = 1; a < RN; a++) begin
            hits = 0;
            for (int p = 0; p < WP; p++)
                if (w_en[p] && int'(w_addr[p]) == a) hits++;
            if (hits >= 2) e.conf = 1'b1;
        end
        return e;
    endfunction

    // Architectural state change at the clock edge.
    task automatic model_edge();
        bit written [RN];
        bit issued  [RN];
        if (!rst_n) begin
            for (int a = 0; a < RN; a++) begin
                mreg[a]  = '0;
                mbusy[a] = 1'b0;
            end
            return;
        end
        for (int a = 0; a < RN; a++) begin
            written[a] = 1'b0;
            issued[a]  = 1'b0;
        end
        for (int p = 0; p < WP; p++) begin
            if (w_en[p]) begin
                written[w_addr[p]] = 1'b1;
                if (w_addr[p] != 0) mreg[w_addr[p]] = w_data[p];
            end
            if (iss_en[p]) issued[iss_addr[p]] = 1'b1;
        end
        for (int a = 1; a < RN; a++) begin
            if (issued[a])       mbusy[a] = 1'b1;
            else if (written[a]) mbusy[a] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        rst_n    = 1'b1;
        w_en     = '0;
        iss_en   = '0;
        w_addr   = '0;
        w_data   = '0;
        iss_addr = '0;
        r_addr   = '0;
    endtask

    // One cycle: predict, enqueue, advance the model, pass the edge.
    task automatic cycle();
        exp_q.push_back(predict());
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic read4(input int a0, input int a1, input int a2, input int a3);
        r_addr[0] = AW'(a0);
        r_addr[1] = AW'(a1);
        r_addr[2] = AW'(a2);
        r_addr[3] = AW'(a3);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare the DUT against the oldest prediction away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int k = 0; k < RP; k++) begin
                check($sformatf("r_data[%0d]", k), r_data[k], e.data[k]);
                check($sformatf("r_busy[%0d]", k), DW'(r_busy[k]), DW'(e.busy[k]));
            end
            check("conflict", DW'(conflict), DW'(e.conf));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < RN; a++) begin
            mreg[a]  = 'x;
            mbusy[a] = 1'b0;
        end
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // 1 Reset held one cycle, then sweep all registers on every port.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int a = 0; a < RN; a += 4) begin
            read4(a, a + 1, a + 2, a + 3);
            cycle();
        end

        // 2 Bypass of a fresh write, then stored value after the edge.
        idle_inputs();
        w_en = 2'b01; w_addr[0] = 5; w_data[0] = 32'hDEAD_BEEF;
        read4(5, 5, 0, 6);
        cycle();
        idle_inputs();
        read4(5, 4, 6, 5);
        cycle();

        // 3 Write to r0 is ignored.
        w_en = 2'b10; w_addr[1] = 0; w_data[1] = 32'h1234;
        read4(0, 0, 5, 0);
        cycle();
        idle_inputs();
        read4(0, 1, 2, 3);
        cycle();

        // 4 Both ports write r7: highest port wins, conflict flagged.
        w_en = 2'b11; w_addr[0] = 7; w_data[0] = 32'h11; w_addr[1] = 7; w_data[1] = 32'h22;
        read4(7, 7, 7, 0);
        cycle();
        idle_inputs();
        read4(7, 0, 7, 5);
        cycle();

        // 5 Issue r9, observe busy, write back with bypass, then cleared.
        iss_en = 2'b01; iss_addr[0] = 9;
        read4(9, 9, 9, 9);
        cycle();
        idle_inputs();
        read4(9, 0, 9, 1);
        cycle();
        w_en = 2'b01; w_addr[0] = 9; w_data[0] = 32'h55;
        read4(9, 9, 0, 7);
        cycle();
        idle_inputs();
        read4(9, 9, 9, 9);
        cycle();

        // 6 Issue and write r3 together (issue wins), then reset mid-sequence.
        iss_en = 2'b10; iss_addr[1] = 3;
        w_en = 2'b01; w_addr[0] = 3; w_data[0] = 32'hCAFE;
        read4(3, 3, 3, 3);
        cycle();
        idle_inputs();
        read4(3, 5, 7, 9);
        cycle();
        rst_n = 1'b0;
        w_en = 2'b11; w_addr[0] = 3; w_addr[1] = 8; w_data[0] = 32'hAA; w_data[1] = 32'hBB;
        iss_en = 2'b01; iss_addr[0] = 4;
        read4(3, 8, 4, 5);
        cycle();
        idle_inputs();
        read4(3, 8, 4, 5);
        cycle();

        // Random traffic concentrated on a few registers to provoke overlaps.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            for (int p = 0; p < WP; p++) begin
                w_en[p]     = $urandom_range(0, 1);
                w_addr[p]   = AW'($urandom_range(0, 7));
                w_data[p]   = $urandom;
                iss_en[p]   = $urandom_range(0, 2) == 0;
                iss_addr[p] = AW'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 3) == 0) w_addr[0] = AW'($urandom_range(0, RN - 1));
            for (int k = 0; k < RP; k++)
                r_addr[k] = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, RN - 1)
                                                         : $urandom_range(0, 7));
            cycle();
        end

        idle_inputs();
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
